// File: rtl/ram_fifo_pkg.sv
// Shared sizing for the RAM-backed stream FIFO.
// Holds default widths, the buffer depth and the occupancy-counter width helper.
package ram_fifo_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned ADDR_W_DEF       = 11;
  localparam int unsigned DEPTH_DEF        = 1 << ADDR_W_DEF;
  localparam int unsigned AFULL_THRESH_DEF = 2040;

  // Occupancy reaches DEPTH + 2, so one bit beyond the address width.
  function automatic int unsigned level_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_if.sv
// Stream, RAM-port and status bundle of the RAM FIFO controller.
// master: the controller (drives s_ready, m_*, ram_wr_*, ram_rd_addr, level, almost_full).
// slave : the parent side (drives s_data/s_valid, m_ready, ram_rd_data).
interface ram_fifo_if
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  localparam int unsigned LVL_W = level_w(ADDR_W);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [LVL_W-1:0]  level;
  logic              almost_full;

  modport master (
    input  s_data, s_valid, m_ready, ram_rd_data,
    output s_ready, m_data, m_valid, ram_wr_data, ram_wr_addr, ram_wr_en,
           ram_rd_addr, level, almost_full
  );

  modport slave (
    output s_data, s_valid, m_ready, ram_rd_data,
    input  s_ready, m_data, m_valid, ram_wr_data, ram_wr_addr, ram_wr_en,
           ram_rd_addr, level, almost_full
  );

endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output skid buffer; entry 0 is always the head.
// Ports: clk, rst_n, clr_i (sync clear), push_i/push_data_i, pop_i, head_o, cnt_o.
module ram_fifo_obuf
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;

  // Next-state: head only changes on pop or on a push into an empty buffer.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      e0_d  = '0;
      e1_d  = '0;
      cnt_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data_i;
          else               e1_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = push_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o = e0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a simple-dual-port RAM with a 1-cycle read.
// Words are prefetched into a 2-entry output buffer for first-word-fall-through.
// Ports: clk, rst_n (async, active low), flush (sync clear), bus (ram_fifo_if.master).
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned AFULL_THRESH = AFULL_THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  ram_fifo_if.master bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LVL_W = level_w(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              almost_full_q;
  logic [1:0]        buf_cnt, buf_cnt_d;
  logic [DATA_W-1:0] head;
  logic              s_ready_c, wr_c, pop_c, issue_c, push_c;

  // Handshakes; issue only while buffer slots (counting a same-cycle pop) outnumber pending words.
  always_comb begin
    s_ready_c = (ram_cnt_q != CNT_W'(DEPTH)) && !flush;
    wr_c      = bus.s_valid && s_ready_c;
    pop_c     = (buf_cnt != 2'd0) && bus.m_ready && !flush;
    push_c    = rd_inflight_q && !flush;
    issue_c   = (ram_cnt_q != '0) && !flush &&
                ((3'(buf_cnt) + 3'(rd_inflight_q)) < (3'd2 + 3'(pop_c)));
  end

  // Next-state of pointers and counts; flush wins over all traffic.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_cnt_d     = ram_cnt_q;
    rd_inflight_d = 1'b0;
    buf_cnt_d     = buf_cnt;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      buf_cnt_d = '0;
    end else begin
      if (wr_c)    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (issue_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      ram_cnt_d     = ram_cnt_q + CNT_W'(wr_c) - CNT_W'(issue_c);
      rd_inflight_d = issue_c;
      buf_cnt_d     = buf_cnt + 2'(push_c) - 2'(pop_c);
    end
    level_d = LVL_W'(ram_cnt_d) + LVL_W'(rd_inflight_d) + LVL_W'(buf_cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      level_q       <= level_d;
      almost_full_q <= (level_d >= LVL_W'(AFULL_THRESH));
    end
  end

  ram_fifo_obuf #(.DATA_W(DATA_W)) u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush),
    .push_i      (push_c),
    .push_data_i (bus.ram_rd_data),
    .pop_i       (pop_c),
    .head_o      (head),
    .cnt_o       (buf_cnt)
  );

  assign bus.s_ready     = s_ready_c;
  assign bus.ram_wr_en   = wr_c;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_wr_data = bus.s_data;
  assign bus.ram_rd_addr = rd_ptr_q;
  assign bus.m_valid     = (buf_cnt != 2'd0);
  assign bus.m_data      = head;
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 2048x16 RAM beside it.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AF    = AFULL_THRESH_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  ram_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THRESH(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Buffer RAM: registered read, data valid the cycle after the address is sampled.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue; level is simply its size.
  logic [DW-1:0] q[$];
  logic          stalled = 1'b0;
  logic [DW-1:0] held    = '0;

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_almost_full", int'(bus.almost_full), 0);
    chk("rst_wr_en", int'(bus.ram_wr_en), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", int'(bus.s_ready), 1);
    q.delete();
    stalled = 1'b0;
  endtask

  // One clock of traffic checked against the queue model.
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr,
                      input logic fl, output logic pp);
    logic hs;
    logic mv;
    logic [DW-1:0] md;
    logic [DW-1:0] exp_d;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    flush       = fl;
    #1;
    hs = bus.s_valid && bus.s_ready;
    mv = bus.m_valid;
    md = bus.m_data;
    pp = mv && mr && !fl;
    if (fl)                     chk("flush_s_ready", int'(bus.s_ready), 0);
    else if (q.size() < DEPTH)  chk("s_ready", int'(bus.s_ready), 1);
    else if (q.size() == DEPTH + 2) chk("full_s_ready", int'(bus.s_ready), 0);
    chk("wr_en", int'(bus.ram_wr_en), int'(hs));
    if (q.size() == 0) chk("empty_m_valid", int'(mv), 0);
    if (stalled) begin
      chk("hold_valid", int'(mv), 1);
      chk("hold_data", int'(md), int'(held));
    end
    if (fl) begin
      q.delete();
    end else begin
      if (pp) begin
        if (q.size() == 0) begin
          chk("pop_from_empty", 1, 0);
        end else begin
          exp_d = q.pop_front();
          chk("m_data", int'(md), int'(exp_d));
        end
      end
      if (hs) q.push_back(sd);
    end
    stalled = !fl && mv && !mr;
    held    = md;
    @(posedge clk);
    #1;
    chk("level", int'(bus.level), q.size());
    chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          fl;
    logic          e_wr_en;
    logic [AW-1:0] e_wr_addr;
    logic [AW-1:0] e_rd_addr;
    logic          e_s_ready;
    logic          e_m_valid;
    logic [DW-1:0] e_m_data;
    logic [AW:0]   e_level;
  } vec_t;

  vec_t tv[12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pp;
    int cyc;
    int popped;

    //            sv  data      mr fl | wr wa rd sr mv  mdata     lvl
    tv[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 1'b1, 1'b0, 16'h0000, 12'd1};
    tv[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 11'd1, 11'd0, 1'b1, 1'b0, 16'h0000, 12'd1};
    tv[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 11'd1, 11'd1, 1'b1, 1'b1, 16'h1234, 12'd1};
    tv[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 11'd1, 11'd1, 1'b1, 1'b1, 16'h1234, 12'd1};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd1, 11'd1, 1'b1, 1'b0, 16'h0000, 12'd0};
    tv[5]  = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b1, 11'd1, 11'd1, 1'b1, 1'b0, 16'h0000, 12'd1};
    tv[6]  = '{1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1, 11'd2, 11'd1, 1'b1, 1'b0, 16'h0000, 12'd2};
    tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd3, 11'd2, 1'b1, 1'b1, 16'hA5A5, 12'd2};
    tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd3, 11'd3, 1'b1, 1'b1, 16'h5A5A, 12'd1};
    tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd3, 11'd3, 1'b1, 1'b0, 16'h0000, 12'd0};
    tv[10] = '{1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 11'd3, 11'd3, 1'b0, 1'b0, 16'h0000, 12'd0};
    tv[11] = '{1'b1, 16'h0BEE, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 1'b1, 1'b0, 16'h0000, 12'd1};

    // Directed cycle-by-cycle vectors: latency, pops, flush pointer reset.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.s_valid = tv[i].sv;
      bus.s_data  = tv[i].sd;
      bus.m_ready = tv[i].mr;
      flush       = tv[i].fl;
      #1;
      chk($sformatf("v%0d_wr_en", i), int'(bus.ram_wr_en), int'(tv[i].e_wr_en));
      chk($sformatf("v%0d_wr_addr", i), int'(bus.ram_wr_addr), int'(tv[i].e_wr_addr));
      chk($sformatf("v%0d_rd_addr", i), int'(bus.ram_rd_addr), int'(tv[i].e_rd_addr));
      chk($sformatf("v%0d_s_ready", i), int'(bus.s_ready), int'(tv[i].e_s_ready));
      if (tv[i].e_wr_en) chk($sformatf("v%0d_wr_data", i), int'(bus.ram_wr_data), int'(tv[i].sd));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_m_valid", i), int'(bus.m_valid), int'(tv[i].e_m_valid));
      chk($sformatf("v%0d_level", i), int'(bus.level), int'(tv[i].e_level));
      if (tv[i].e_m_valid) chk($sformatf("v%0d_m_data", i), int'(bus.m_data), int'(tv[i].e_m_data));
    end

    // Fill to DEPTH+2 with the sink stalled.
    do_reset();
    for (int c = 0; c < 2300 && q.size() < DEPTH + 2; c++)
      step(1'b1, DW'(q.size()), 1'b0, 1'b0, pp);
    chk("fill_count", q.size(), DEPTH + 2);
    chk("fill_level", int'(bus.level), DEPTH + 2);
    chk("fill_almost_full", int'(bus.almost_full), 1);
    for (int c = 0; c < 3; c++) step(1'b1, 16'hFFFF, 1'b0, 1'b0, pp);

    // Drain with pointer wrap; one word per cycle with no gaps.
    cyc = 0;
    for (int c = 0; c < 2300 && q.size() != 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, pp);
      cyc++;
    end
    chk("drain_cycles", cyc, DEPTH + 2);
    chk("drain_m_valid", int'(bus.m_valid), 0);
    chk("drain_level", int'(bus.level), 0);

    // Continuous streaming: one word per cycle, level settles at 2..3.
    for (int c = 0; c < 300; c++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0, pp);
      if (c >= 5) begin
        chk("stream_pop", int'(pp), 1);
        chk("stream_level_band", int'(bus.level >= 2 && bus.level <= 3), 1);
      end
    end

    // Random source and 50% sink backpressure, 10k words.
    popped = 0;
    for (int c = 0; c < 60000 && popped < 10000; c++) begin
      step(($urandom_range(0, 99) < 70), DW'($urandom), 1'(($urandom_range(0, 1))), 1'b0, pp);
      if (pp) popped++;
    end
    chk("random_words", int'(popped >= 10000), 1);

    // Asynchronous reset while traffic is pending.
    do_reset();

    // Flush with 100 stored words and a read in flight.
    for (int c = 0; c < 200 && q.size() < 100; c++)
      step(1'b1, DW'($urandom), 1'b0, 1'b0, pp);
    chk("pre_flush_count", q.size(), 100);
    step(1'b0, '0, 1'b1, 1'b0, pp);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, pp);
    chk("post_flush_m_valid", int'(bus.m_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0, pp);
    step(1'b0, '0, 1'b1, 1'b0, pp);
    chk("post_flush_quiet", int'(bus.m_valid), 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hBEEF;
    bus.m_ready = 1'b0;
    #1;
    chk("beef_s_ready", int'(bus.s_ready), 1);
    chk("beef_wr_addr", int'(bus.ram_wr_addr), 0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, pp);
    popped = 0;
    for (int c = 0; c < 10 && popped == 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, pp);
      if (pp) popped++;
    end
    chk("beef_emerged", popped, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the 2048x16 simple-dual-port buffer RAM (ram_fifo) and converts it into a valid/ready stream FIFO.
- Upstream stream writes land in RAM through the write port.
- Words are prefetched through the read port into a 2-entry output buffer, giving first-word-fall-through output.
- The parent instantiates the RAM beside this block and ties both RAM clocks to clk and both RAM resets to ~rst_n.

Parameters:
DATA_W, 16, stream/RAM data width; must equal the RAM data width.
ADDR_W, 11, RAM address width; DEPTH = 2**ADDR_W (localparam, 2048).
AFULL_THRESH, 2040, level at or above which almost_full asserts; legal range 1..DEPTH+2.

Ports:
clk  in  1  single clock for all logic and both RAM ports.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of all contents.
s_data  in  DATA_W  upstream write data.
s_valid  in  1  upstream data valid.
s_ready  out  1  FIFO can accept a word.
m_data  out  DATA_W  downstream read data.
m_valid  out  1  m_data valid.
m_ready  in  1  downstream accepts.
ram_wr_data  out  DATA_W  to RAM wr_data.
ram_wr_addr  out  ADDR_W  to RAM wr_addr.
ram_wr_en  out  1  to RAM wr_en.
ram_rd_addr  out  ADDR_W  to RAM rd_addr.
ram_rd_data  in  DATA_W  from RAM rd_data; valid the cycle after rd_addr is sampled (no output register).
level  out  ADDR_W+1  total words held: RAM + in-flight + output buffer, range 0..DEPTH+2.
almost_full  out  1  registered; level >= AFULL_THRESH.

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_W each, wrap DEPTH-1 -> 0 naturally); ram_cnt (0..DEPTH); rd_inflight (1 bit); obuf of 2 entries with buf_cnt (0..2).
- Reset (async, rst_n=0): pointers, counts, rd_inflight, buf_cnt, level all 0. m_valid=0, almost_full=0, ram_wr_en=0, m_data=0. s_ready=1 once reset is released.
- Write:
  - s_ready = (ram_cnt != DEPTH) && !flush.
  - On a handshake, ram_wr_en=1 combinationally in the same cycle, with ram_wr_addr=wr_ptr and ram_wr_data=s_data.
  - At the edge, wr_ptr increments and ram_cnt increments.
  - If s_valid is high while full: no write, no state change.
- Read issue:
  - credit = 2 - buf_cnt - rd_inflight + (m_valid && m_ready).
  - Issue when ram_cnt != 0 && credit > 0 && !flush.
  - Issue drives ram_rd_addr=rd_ptr; at the edge rd_ptr++, ram_cnt--, rd_inflight=1.
  - ram_rd_addr holds rd_ptr when idle.
- Capture: in the cycle after an issue, ram_rd_data is pushed into obuf and rd_inflight clears unless a new issue occurs.
- Output:
  - m_valid = buf_cnt != 0; m_data is the obuf head.
  - m_data is stable while m_valid && !m_ready.
  - Pop on m_valid && m_ready.
- Latency: a word accepted at edge E0 shows m_valid after edge E2 (issue in cycle E0..E1, capture at E2), provided obuf has room.
- Simultaneous write+issue: ram_cnt is unchanged; wr_ptr and rd_ptr both advance. A read never targets a word written in the same cycle, because ram_cnt counts only committed writes.
- Simultaneous capture+pop with buf_cnt=2 is legal; obuf never overflows.
- level updates every edge: ram_cnt + rd_inflight + buf_cnt. almost_full is registered from the next-state level.
- Full: s_ready=0 when ram_cnt=DEPTH, so total capacity is DEPTH+2 when obuf is also full.
- Empty: m_valid=0 only when buf_cnt=0.
- Flush (synchronous, priority over all traffic):
  - Same-cycle writes and pops are ignored; an in-flight read is discarded.
  - Next cycle: all counts 0, pointers 0, m_valid=0.
- Reset asserted mid-transfer: all state clears immediately; RAM contents are don't-care.

Decomposition:
- Package ram_fifo_pkg: DATA_W/ADDR_W defaults, DEPTH localparam, level width function.
- Sub-module ram_fifo_obuf: 2-entry skid buffer with push/pop/buf_cnt/head outputs and synchronous clear. The controller keeps pointers, counts, issue logic and flags.

Test Plan:
- Reset, then one write 0x1234 at edge E0 -> ram_wr_en=1 at addr 0 in that cycle; m_valid=1 after E2 with m_data=0x1234; level=1 through E1..E2.
- Write 2050 words (0..2049) with m_ready=0 -> s_ready drops after word 2049 is accepted; level=2050; almost_full=1 from level 2040; further s_valid causes no write.
- Drain the previous full FIFO with m_ready=1 -> outputs 0..2049 in order with no gaps after the first; wr_ptr/rd_ptr wrap through 2047 -> 0; level returns to 0, m_valid=0.
- Continuous s_valid=1 and m_ready=1 at steady state -> one word per cycle; level constant at 2-3; no drops or duplicates; scoreboard matches.
- Random m_ready backpressure (50%) over 10k words -> m_data held stable while stalled; in-order, lossless.
- flush with 100 words stored and a read in flight -> next cycle level=0, m_valid=0, s_ready=1; the next write 0xBEEF emerges first at RAM addr 0.
